// File: rtl/scs8hd_pwrgate_seq.sv
// Power-gating sequencer for one switchable scs8hd domain: staggered header
// switch ramp, isolation/retention ordering and req/ack handshake.
module scs8hd_pwrgate_seq #(
    parameter int NSEG     = 4,
    parameter int STEP_CYC = 8,
    parameter int ISO_CYC  = 2,
    parameter int GOOD_TMO = 64
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            pwr_req,
    input  logic            vpwr_good,
    output logic            pwr_ack,
    output logic [NSEG-1:0] sw_en,
    output logic            iso_en,
    output logic            ret_save,
    output logic            ret_restore,
    output logic            busy,
    output logic            fault,
    output logic [3:0]      state
);

    localparam int CNT_MAX0 = (STEP_CYC > ISO_CYC) ? STEP_CYC : ISO_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > GOOD_TMO) ? CNT_MAX0 : GOOD_TMO;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] ISO_LAST  = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(GOOD_TMO - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_RAMP_UP   = 4'd1,
        S_WAIT_GOOD = 4'd2,
        S_RESTORE   = 4'd3,
        S_DEISO     = 4'd4,
        S_ON        = 4'd5,
        S_ISO       = 4'd6,
        S_SAVE      = 4'd7,
        S_RAMP_DN   = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [NSEG-1:0] sw_en_q, sw_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic            iso_q, ack_q, save_q, restore_q, busy_q;
    logic [NSEG-1:0] sw_dn;

    // Clearing the highest set bit of a thermometer code is a right shift.
    assign sw_dn = sw_en_q >> 1;

    always_comb begin
        state_d = state_q;
        sw_en_d = sw_en_q;
        fault_d = fault_q;
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_OFF: begin
                if (pwr_req && !fault_q) begin
                    state_d = S_RAMP_UP;
                    sw_en_d = NSEG'(1);
                    cnt_d   = '0;
                end
            end
            S_RAMP_UP: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (sw_en_q[NSEG-1]) state_d = S_WAIT_GOOD;
                    else                 sw_en_d = (sw_en_q << 1) | NSEG'(1);
                end
            end
            S_WAIT_GOOD: begin
                if (vpwr_good) begin
                    state_d = S_RESTORE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    // Rail never came up: collapse straight to ramp-down, still isolated.
                    fault_d = 1'b1;
                    sw_en_d = sw_dn;
                    cnt_d   = '0;
                    state_d = (sw_dn == '0) ? S_OFF : S_RAMP_DN;
                end
            end
            S_RESTORE: begin
                state_d = S_DEISO;
                cnt_d   = '0;
            end
            S_DEISO: begin
                if (cnt_q == ISO_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (!pwr_req) begin
                    state_d = S_ISO;
                    cnt_d   = '0;
                end
            end
            S_ISO: begin
                if (cnt_q == ISO_LAST) begin
                    state_d = S_SAVE;
                    cnt_d   = '0;
                end
            end
            S_SAVE: begin
                sw_en_d = sw_dn;
                cnt_d   = '0;
                state_d = (sw_dn == '0) ? S_OFF : S_RAMP_DN;
            end
            S_RAMP_DN: begin
                if (cnt_q == STEP_LAST) begin
                    sw_en_d = sw_dn;
                    cnt_d   = '0;
                    if (sw_dn == '0) state_d = S_OFF;
                end
            end
            default: begin
                state_d = S_OFF;
                sw_en_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered versions of the decode of the next state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_OFF;
            sw_en_q   <= '0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            iso_q     <= 1'b1;
            ack_q     <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_en_q   <= sw_en_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            iso_q     <= (state_d != S_ON);
            ack_q     <= (state_d == S_ON);
            save_q    <= (state_d == S_SAVE);
            restore_q <= (state_d == S_RESTORE);
            busy_q    <= (state_d != S_OFF) && (state_d != S_ON);
        end
    end

    assign state       = state_q;
    assign sw_en       = sw_en_q;
    assign fault       = fault_q;
    assign iso_en      = iso_q;
    assign pwr_ack     = ack_q;
    assign ret_save    = save_q;
    assign ret_restore = restore_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_scs8hd_pwrgate_seq.sv
// Directed bench for scs8hd_pwrgate_seq with NSEG=4, STEP_CYC=8, ISO_CYC=2, GOOD_TMO=64.
module tb_scs8hd_pwrgate_seq;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       pwr_req = 1'b0;
    logic       vpwr_good = 1'b0;
    logic       pwr_ack;
    logic [3:0] sw_en;
    logic       iso_en, ret_save, ret_restore, busy, fault;
    logic [3:0] state;

    int checks = 0;
    int passes = 0;

    // {state, sw_en, iso_en, pwr_ack, ret_restore, ret_save, busy, fault}
    logic [13:0] obs;
    assign obs = {state, sw_en, iso_en, pwr_ack, ret_restore, ret_save, busy, fault};

    scs8hd_pwrgate_seq #(.NSEG(4), .STEP_CYC(8), .ISO_CYC(2), .GOOD_TMO(64)) dut (
        .clk(clk), .resetb(resetb), .pwr_req(pwr_req), .vpwr_good(vpwr_good),
        .pwr_ack(pwr_ack), .sw_en(sw_en), .iso_en(iso_en), .ret_save(ret_save),
        .ret_restore(ret_restore), .busy(busy), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetb  = 1'b0;
        pwr_req = 1'b0;
        tick(2);
        resetb  = 1'b1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        tick(2);
        if (obs !== {4'd0, 4'b0000, 6'b100000}) begin
            $display("FAIL reset_values got %h want %h", obs, {4'd0, 4'b0000, 6'b100000});
        end else passes++;
        checks++;
        resetb = 1'b1;
        tick(3);
        if (obs !== {4'd0, 4'b0000, 6'b100000}) begin
            $display("FAIL idle_after_reset got %h want %h", obs, {4'd0, 4'b0000, 6'b100000});
        end else passes++;
        checks++;
    endtask

    task automatic test_power_up();
        int          ofs [11] = '{1, 8, 9, 17, 25, 32, 33, 34, 35, 36, 37};
        logic [13:0] ex  [11] = '{
            {4'd1, 4'b0001, 6'b100010}, {4'd1, 4'b0001, 6'b100010},
            {4'd1, 4'b0011, 6'b100010}, {4'd1, 4'b0111, 6'b100010},
            {4'd1, 4'b1111, 6'b100010}, {4'd1, 4'b1111, 6'b100010},
            {4'd2, 4'b1111, 6'b100010}, {4'd3, 4'b1111, 6'b101010},
            {4'd4, 4'b1111, 6'b100010}, {4'd4, 4'b1111, 6'b100010},
            {4'd5, 4'b1111, 6'b010000}};
        int now = 0;
        vpwr_good = 1'b1;
        pwr_req   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick(ofs[i] - now);
            now = ofs[i];
            if (obs !== ex[i]) begin
                $display("FAIL power_up_t%0d got %h want %h", ofs[i], obs, ex[i]);
            end else passes++;
            checks++;
        end
    endtask

    task automatic test_power_down();
        int          ofs [8] = '{1, 2, 3, 4, 12, 20, 27, 28};
        logic [13:0] ex  [8] = '{
            {4'd6, 4'b1111, 6'b100010}, {4'd6, 4'b1111, 6'b100010},
            {4'd7, 4'b1111, 6'b100110}, {4'd8, 4'b0111, 6'b100010},
            {4'd8, 4'b0011, 6'b100010}, {4'd8, 4'b0001, 6'b100010},
            {4'd8, 4'b0001, 6'b100010}, {4'd0, 4'b0000, 6'b100000}};
        int now = 0;
        pwr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(ofs[i] - now);
            now = ofs[i];
            if (obs !== ex[i]) begin
                $display("FAIL power_down_t%0d got %h want %h", ofs[i], obs, ex[i]);
            end else passes++;
            checks++;
        end
    endtask

    task automatic test_timeout();
        int          ofs [7] = '{25, 33, 96, 97, 105, 113, 121};
        logic [13:0] ex  [7] = '{
            {4'd1, 4'b1111, 6'b100010}, {4'd2, 4'b1111, 6'b100010},
            {4'd2, 4'b1111, 6'b100010}, {4'd8, 4'b0111, 6'b100011},
            {4'd8, 4'b0011, 6'b100011}, {4'd8, 4'b0001, 6'b100011},
            {4'd0, 4'b0000, 6'b100001}};
        int   now = 0;
        logic pulse = 1'b0;
        do_reset();
        vpwr_good = 1'b0;
        pwr_req   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            while (now < ofs[i]) begin
                tick(1);
                now++;
                pulse = pulse | ret_save | ret_restore | ~iso_en;
            end
            if (obs !== ex[i]) begin
                $display("FAIL timeout_t%0d got %h want %h", ofs[i], obs, ex[i]);
            end else passes++;
            checks++;
        end
        if (pulse !== 1'b0) begin
            $display("FAIL timeout_no_pulse got %b want 0", pulse);
        end else passes++;
        checks++;
        tick(10);
        if (obs !== {4'd0, 4'b0000, 6'b100001}) begin
            $display("FAIL fault_blocks_req got %h want %h", obs, {4'd0, 4'b0000, 6'b100001});
        end else passes++;
        checks++;
        resetb = 1'b0;
        tick(1);
        resetb = 1'b1;
        tick(1);
        if (obs !== {4'd1, 4'b0001, 6'b100010}) begin
            $display("FAIL req_after_reset got %h want %h", obs, {4'd1, 4'b0001, 6'b100010});
        end else passes++;
        checks++;
    endtask

    task automatic test_mid_change();
        do_reset();
        vpwr_good = 1'b1;
        pwr_req   = 1'b1;
        tick(9);
        if (obs !== {4'd1, 4'b0011, 6'b100010}) begin
            $display("FAIL mid_at_0011 got %h want %h", obs, {4'd1, 4'b0011, 6'b100010});
        end else passes++;
        checks++;
        pwr_req = 1'b0;
        tick(28);
        if (obs !== {4'd5, 4'b1111, 6'b010000}) begin
            $display("FAIL mid_reaches_on got %h want %h", obs, {4'd5, 4'b1111, 6'b010000});
        end else passes++;
        checks++;
        tick(1);
        if (obs !== {4'd6, 4'b1111, 6'b100010}) begin
            $display("FAIL mid_iso_next got %h want %h", obs, {4'd6, 4'b1111, 6'b100010});
        end else passes++;
        checks++;
        tick(3);
        if (obs !== {4'd8, 4'b0111, 6'b100010}) begin
            $display("FAIL mid_ramp_dn got %h want %h", obs, {4'd8, 4'b0111, 6'b100010});
        end else passes++;
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        vpwr_good = 1'b1;
        pwr_req   = 1'b1;
        tick(17);
        if (obs !== {4'd1, 4'b0111, 6'b100010}) begin
            $display("FAIL async_pre got %h want %h", obs, {4'd1, 4'b0111, 6'b100010});
        end else passes++;
        checks++;
        #2;
        resetb = 1'b0;
        #1;
        if (obs !== {4'd0, 4'b0000, 6'b100000}) begin
            $display("FAIL async_reset got %h want %h", obs, {4'd0, 4'b0000, 6'b100000});
        end else passes++;
        checks++;
        pwr_req = 1'b0;
        tick(1);
        resetb = 1'b1;
    endtask

    task automatic test_invariants();
        logic [3:0] prev;
        do_reset();
        prev = sw_en;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 47) == 0) pwr_req = ~pwr_req;
            vpwr_good = ($urandom_range(0, 7) != 0);
            tick(1);
            if (!pwr_ack && !iso_en) begin
                $display("FAIL inv_iso cycle %0d got iso_en=0 want 1", c);
            end else passes++;
            checks++;
            if (((sw_en & (sw_en + 4'd1)) != 4'd0) || ($countones(sw_en ^ prev) > 1)) begin
                $display("FAIL inv_sw cycle %0d got %b prev %b want thermometer single-step", c, sw_en, prev);
            end else passes++;
            checks++;
            if (ret_save && ret_restore) begin
                $display("FAIL inv_ret cycle %0d got save=1 restore=1 want exclusive", c);
            end else passes++;
            checks++;
            prev = sw_en;
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_timeout();
        test_mid_change();
        test_async_reset();
        test_invariants();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
